// File: rtl/iob_ahb_ram_arb.sv
// iob_ahb_ram_arb
// Two-manager AHB-lite arbiter in front of a single subordinate (typically a RAM).
// Each beat is forwarded as an independent NONSEQ transfer. Beats from the two
// managers may interleave.
//
// Ports
//   clk_i, arst_i                   clock, asynchronous active-high reset
//   mK_hsel_i .. mK_hwdata_i        manager K address/data phase inputs (K = 0,1)
//   mK_hreadyout_o                  manager K ready (also that manager's HREADY)
//   mK_hrdata_o                     manager K read data (subordinate data passed through)
//   s_hsel_o .. s_hwdata_o          forwarded subordinate bus
//   s_hready_o                      subordinate HREADY
//   s_hreadyout_i, s_hrdata_i       subordinate response
//
// A request that loses arbitration, or that arrives while the subordinate is
// stalled, is parked in a per-manager holding register. That manager is then
// held off with hreadyout=0 until the parked beat has been issued.
module iob_ahb_ram_arb #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              m0_hsel_i,
    input  logic [ADDR_W-1:0] m0_haddr_i,
    input  logic [1:0]        m0_htrans_i,
    input  logic              m0_hwrite_i,
    input  logic [2:0]        m0_hsize_i,
    input  logic [DATA_W-1:0] m0_hwdata_i,
    output logic              m0_hreadyout_o,
    output logic [DATA_W-1:0] m0_hrdata_o,
    input  logic              m1_hsel_i,
    input  logic [ADDR_W-1:0] m1_haddr_i,
    input  logic [1:0]        m1_htrans_i,
    input  logic              m1_hwrite_i,
    input  logic [2:0]        m1_hsize_i,
    input  logic [DATA_W-1:0] m1_hwdata_i,
    output logic              m1_hreadyout_o,
    output logic [DATA_W-1:0] m1_hrdata_o,
    output logic              s_hsel_o,
    output logic [ADDR_W-1:0] s_haddr_o,
    output logic [1:0]        s_htrans_o,
    output logic              s_hwrite_o,
    output logic [2:0]        s_hsize_o,
    output logic [DATA_W-1:0] s_hwdata_o,
    output logic              s_hready_o,
    input  logic              s_hreadyout_i,
    input  logic [DATA_W-1:0] s_hrdata_i
);

    logic              pend0_q, pend0_d, pend1_q, pend1_d;
    logic [ADDR_W-1:0] hold0_addr_q, hold0_addr_d, hold1_addr_q, hold1_addr_d;
    logic              hold0_write_q, hold0_write_d, hold1_write_q, hold1_write_d;
    logic [2:0]        hold0_size_q, hold0_size_d, hold1_size_q, hold1_size_d;
    logic              last_grant_q, last_grant_d;
    logic              d_vld_q, d_vld_d;
    logic              d_own_q, d_own_d;

    logic live0, live1, req0, req1, can_issue, gnt0, gnt1, issue;
    logic unused_htrans_lsb;

    // SEQ/NONSEQ differ only in bit 0; every forwarded beat is NONSEQ, so bit 0 is ignored.
    assign unused_htrans_lsb = m0_htrans_i[0] ^ m1_htrans_i[0];

    // Manager-side ready: a parked beat holds its manager off. The data-phase
    // owner follows the subordinate. An idle manager is always ready.
    assign m0_hreadyout_o = pend0_q ? 1'b0 : ((d_vld_q && !d_own_q) ? s_hreadyout_i : 1'b1);
    assign m1_hreadyout_o = pend1_q ? 1'b0 : ((d_vld_q &&  d_own_q) ? s_hreadyout_i : 1'b1);
    assign m0_hrdata_o    = s_hrdata_i;
    assign m1_hrdata_o    = s_hrdata_i;
    assign s_hready_o     = s_hreadyout_i;
    assign s_hwdata_o     = d_vld_q ? (d_own_q ? m1_hwdata_i : m0_hwdata_i) : {DATA_W{1'b0}};

    // Request detection, round-robin grant and address-phase forwarding.
    always_comb begin
        live0     = m0_hsel_i & m0_htrans_i[1] & m0_hreadyout_o;
        live1     = m1_hsel_i & m1_htrans_i[1] & m1_hreadyout_o;
        req0      = live0 | pend0_q;
        req1      = live1 | pend1_q;
        // Nothing is issued while the subordinate stalls or while reset is asserted.
        can_issue = s_hreadyout_i & ~arst_i;
        // On a tie the manager that did not win last time gets the bus.
        gnt0      = can_issue & req0 & (~req1 | last_grant_q);
        gnt1      = can_issue & req1 & (~req0 | ~last_grant_q);
        issue     = gnt0 | gnt1;

        s_hsel_o   = issue;
        s_htrans_o = issue ? 2'b10 : 2'b00;
        if (gnt1) begin
            s_haddr_o  = pend1_q ? hold1_addr_q  : m1_haddr_i;
            s_hwrite_o = pend1_q ? hold1_write_q : m1_hwrite_i;
            s_hsize_o  = pend1_q ? hold1_size_q  : m1_hsize_i;
        end else begin
            s_haddr_o  = pend0_q ? hold0_addr_q  : m0_haddr_i;
            s_hwrite_o = pend0_q ? hold0_write_q : m0_hwrite_i;
            s_hsize_o  = pend0_q ? hold0_size_q  : m0_hsize_i;
        end
    end

    // Next-state for the holding registers, the pending flags, the grant history and data-phase tracking.
    always_comb begin
        pend0_d       = pend0_q;
        pend1_d       = pend1_q;
        hold0_addr_d  = hold0_addr_q;
        hold0_write_d = hold0_write_q;
        hold0_size_d  = hold0_size_q;
        hold1_addr_d  = hold1_addr_q;
        hold1_write_d = hold1_write_q;
        hold1_size_d  = hold1_size_q;
        last_grant_d  = last_grant_q;
        d_vld_d       = d_vld_q;
        d_own_d       = d_own_q;

        if (gnt0) begin
            pend0_d = 1'b0;
        end else if (live0) begin
            pend0_d       = 1'b1;
            hold0_addr_d  = m0_haddr_i;
            hold0_write_d = m0_hwrite_i;
            hold0_size_d  = m0_hsize_i;
        end else begin
            pend0_d = pend0_q;
        end

        if (gnt1) begin
            pend1_d = 1'b0;
        end else if (live1) begin
            pend1_d       = 1'b1;
            hold1_addr_d  = m1_haddr_i;
            hold1_write_d = m1_hwrite_i;
            hold1_size_d  = m1_hsize_i;
        end else begin
            pend1_d = pend1_q;
        end

        if (issue) begin
            last_grant_d = gnt1;
            d_vld_d      = 1'b1;
            d_own_d      = gnt1;
        end else if (s_hreadyout_i) begin
            d_vld_d = 1'b0;
        end else begin
            d_vld_d = d_vld_q;
        end
    end

    // State registers. Reset drops every parked and in-flight beat.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pend0_q       <= 1'b0;
            pend1_q       <= 1'b0;
            hold0_addr_q  <= {ADDR_W{1'b0}};
            hold0_write_q <= 1'b0;
            hold0_size_q  <= 3'b000;
            hold1_addr_q  <= {ADDR_W{1'b0}};
            hold1_write_q <= 1'b0;
            hold1_size_q  <= 3'b000;
            last_grant_q  <= 1'b1;
            d_vld_q       <= 1'b0;
            d_own_q       <= 1'b0;
        end else begin
            pend0_q       <= pend0_d;
            pend1_q       <= pend1_d;
            hold0_addr_q  <= hold0_addr_d;
            hold0_write_q <= hold0_write_d;
            hold0_size_q  <= hold0_size_d;
            hold1_addr_q  <= hold1_addr_d;
            hold1_write_q <= hold1_write_d;
            hold1_size_q  <= hold1_size_d;
            last_grant_q  <= last_grant_d;
            d_vld_q       <= d_vld_d;
            d_own_q       <= d_own_d;
        end
    end

endmodule

// File: tb/tb_iob_ahb_ram_arb.sv
// Testbench for iob_ahb_ram_arb. It contains two AHB-lite manager models, a
// word RAM subordinate model and a reference memory that is updated in the
// order each manager sees its own beats complete.
module tb_iob_ahb_ram_arb;
    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic arst_i;
    logic m0_hsel_i, m0_hwrite_i, m1_hsel_i, m1_hwrite_i;
    logic [AW-1:0] m0_haddr_i, m1_haddr_i, s_haddr_o;
    logic [1:0] m0_htrans_i, m1_htrans_i, s_htrans_o;
    logic [2:0] m0_hsize_i, m1_hsize_i, s_hsize_o;
    logic [DW-1:0] m0_hwdata_i, m1_hwdata_i, m0_hrdata_o, m1_hrdata_o, s_hwdata_o, s_hrdata_i;
    logic m0_hreadyout_o, m1_hreadyout_o, s_hsel_o, s_hwrite_o, s_hready_o, s_hreadyout_i;

    iob_ahb_ram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .arst_i(arst_i),
        .m0_hsel_i(m0_hsel_i), .m0_haddr_i(m0_haddr_i), .m0_htrans_i(m0_htrans_i),
        .m0_hwrite_i(m0_hwrite_i), .m0_hsize_i(m0_hsize_i), .m0_hwdata_i(m0_hwdata_i),
        .m0_hreadyout_o(m0_hreadyout_o), .m0_hrdata_o(m0_hrdata_o),
        .m1_hsel_i(m1_hsel_i), .m1_haddr_i(m1_haddr_i), .m1_htrans_i(m1_htrans_i),
        .m1_hwrite_i(m1_hwrite_i), .m1_hsize_i(m1_hsize_i), .m1_hwdata_i(m1_hwdata_i),
        .m1_hreadyout_o(m1_hreadyout_o), .m1_hrdata_o(m1_hrdata_o),
        .s_hsel_o(s_hsel_o), .s_haddr_o(s_haddr_o), .s_htrans_o(s_htrans_o),
        .s_hwrite_o(s_hwrite_o), .s_hsize_o(s_hsize_o), .s_hwdata_o(s_hwdata_o),
        .s_hready_o(s_hready_o), .s_hreadyout_i(s_hreadyout_i), .s_hrdata_i(s_hrdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          sel;
        logic [1:0]    trans;
        logic          wr;
        logic [31:0]   wdata;
    } beat_t;

    beat_t q0[$], q1[$], exp0[$], exp1[$];
    beat_t aph [2];
    beat_t dph [2];
    bit    aph_v [2];
    bit    dph_v [2];
    int    dwait [2];
    int    wlog0[$], wlog1[$];
    logic [AW-1:0] ilog[$];
    logic [31:0] ram [0:4095];
    logic [31:0] ref_mem [0:4095];
    bit r_dph_v;
    logic r_dph_wr;
    logic [AW-1:0] r_dph_addr;
    bit rand_rdy;
    logic rdy_next;
    int n_cmp, n_fail;

    logic c_hr0, c_hr1, c_sr, c_hsel, c_hwrite;
    logic [1:0] c_htrans;
    logic [AW-1:0] c_haddr;
    logic [31:0] c_hwdata, c_hrdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int k, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [AW-1:0] a, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.sel = sel; b.trans = tr; b.wr = wr; b.wdata = d;
        if (k == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic models_reset();
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        for (int k = 0; k < 2; k++) begin aph_v[k] = 0; dph_v[k] = 0; dwait[k] = 0; end
        r_dph_v = 0;
    endtask

    function automatic bit busy();
        return (q0.size() != 0) || (q1.size() != 0) || aph_v[0] || aph_v[1] ||
               dph_v[0] || dph_v[1] || r_dph_v;
    endfunction

    task automatic drive();
        m0_hsel_i   = aph_v[0] && aph[0].sel;
        m0_htrans_i = aph_v[0] ? aph[0].trans : 2'b00;
        m0_haddr_i  = aph[0].addr;
        m0_hwrite_i = aph[0].wr;
        m0_hsize_i  = 3'b010;
        m0_hwdata_i = dph_v[0] ? dph[0].wdata : 32'd0;
        m1_hsel_i   = aph_v[1] && aph[1].sel;
        m1_htrans_i = aph_v[1] ? aph[1].trans : 2'b00;
        m1_haddr_i  = aph[1].addr;
        m1_hwrite_i = aph[1].wr;
        m1_hsize_i  = 3'b010;
        m1_hwdata_i = dph_v[1] ? dph[1].wdata : 32'd0;
    endtask

    // Capture everything at the falling edge and check bus-level invariants.
    task automatic sample();
        @(negedge clk);
        c_hr0 = m0_hreadyout_o; c_hr1 = m1_hreadyout_o; c_sr = s_hreadyout_i;
        c_hsel = s_hsel_o; c_htrans = s_htrans_o; c_haddr = s_haddr_o;
        c_hwrite = s_hwrite_o; c_hwdata = s_hwdata_o; c_hrdata = m0_hrdata_o;
        chk("s_htrans_vs_hsel", {30'd0, s_htrans_o}, c_hsel ? 32'd2 : 32'd0);
        chk("s_hready_pass", {31'd0, s_hready_o}, {31'd0, s_hreadyout_i});
        if (!r_dph_v) chk("s_hwdata_idle", s_hwdata_o, 32'd0);
    endtask

    task automatic ram_step();
        bit found;
        if (c_sr) begin
            if (r_dph_v && r_dph_wr) ram[r_dph_addr[AW-1:2]] = c_hwdata;
            r_dph_v = c_hsel && c_htrans[1];
            if (r_dph_v) begin
                r_dph_addr = c_haddr;
                r_dph_wr   = c_hwrite;
                ilog.push_back(c_haddr);
                found = 0;
                if (exp0.size() > 0 && exp0[0].addr == c_haddr && exp0[0].wr == c_hwrite) begin
                    void'(exp0.pop_front()); found = 1;
                end else if (exp1.size() > 0 && exp1[0].addr == c_haddr && exp1[0].wr == c_hwrite) begin
                    void'(exp1.pop_front()); found = 1;
                end
                chk($sformatf("issue_in_order@%h", c_haddr), {31'd0, found}, 32'd1);
            end
        end
    endtask

    task automatic bfm_step(input int k);
        logic hr;
        hr = (k == 0) ? c_hr0 : c_hr1;
        if (hr) begin
            if (dph_v[k]) begin
                if (dph[k].wr) ref_mem[dph[k].addr[AW-1:2]] = dph[k].wdata;
                else chk($sformatf("m%0d_rdata@%h", k, dph[k].addr), c_hrdata, ref_mem[dph[k].addr[AW-1:2]]);
                if (k == 0) wlog0.push_back(dwait[k]); else wlog1.push_back(dwait[k]);
            end
            dph_v[k] = aph_v[k] && aph[k].sel && (aph[k].trans == 2'b10);
            dph[k]   = aph[k];
            dwait[k] = 0;
            aph_v[k] = 0;
            if (k == 0 && q0.size() > 0) begin aph[k] = q0.pop_front(); aph_v[k] = 1; end
            else if (k == 1 && q1.size() > 0) begin aph[k] = q1.pop_front(); aph_v[k] = 1; end
            if (aph_v[k] && aph[k].sel && aph[k].trans == 2'b10) begin
                if (k == 0) exp0.push_back(aph[k]); else exp1.push_back(aph[k]);
            end
        end else if (dph_v[k]) begin
            dwait[k]++;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        ram_step();
        bfm_step(0);
        bfm_step(1);
        drive();
        s_hreadyout_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_next;
        s_hrdata_i    = r_dph_v ? ram[r_dph_addr[AW-1:2]] : $urandom;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && busy(); i++) begin advance(); sample(); end
        chk("drain_done", {31'd0, busy()}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        n_cmp = 0; n_fail = 0; rand_rdy = 0; rdy_next = 1'b1;
        for (int i = 0; i < 4096; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
        ilog.delete(); wlog0.delete(); wlog1.delete();
        models_reset();
        for (int k = 0; k < 2; k++) begin
            aph[k].addr = '0; aph[k].sel = 0; aph[k].trans = 2'b00; aph[k].wr = 0; aph[k].wdata = '0;
            dph[k] = aph[k];
        end

        // Reset with both managers presenting live NONSEQ writes.
        arst_i = 1'b1; s_hreadyout_i = 1'b1; s_hrdata_i = 32'd0;
        m0_hsel_i = 1'b1; m0_htrans_i = 2'b10; m0_haddr_i = 14'h010; m0_hwrite_i = 1'b1;
        m0_hsize_i = 3'b010; m0_hwdata_i = 32'hDEADBEEF;
        m1_hsel_i = 1'b1; m1_htrans_i = 2'b10; m1_haddr_i = 14'h040; m1_hwrite_i = 1'b1;
        m1_hsize_i = 3'b010; m1_hwdata_i = 32'hCAFEF00D;
        sample();
        chk("rst_hsel", {31'd0, c_hsel}, 32'd0);
        chk("rst_htrans", {30'd0, c_htrans}, 32'd0);
        chk("rst_hwdata", c_hwdata, 32'd0);
        chk("rst_hr0", {31'd0, c_hr0}, 32'd1);
        chk("rst_hr1", {31'd0, c_hr1}, 32'd1);
        #2;
        arst_i = 1'b0;
        drive();

        // Simultaneous NONSEQ after reset: m0 wins, m1 parked for one cycle.
        push(0, 1'b1, 2'b10, 1'b1, 14'h020, 32'h00000011);
        push(1, 1'b1, 2'b10, 1'b1, 14'h040, 32'h00000022);
        advance(); sample();
        chk("tie_c0_hsel", {31'd0, c_hsel}, 32'd1);
        chk("tie_c0_addr", {18'd0, c_haddr}, 32'h020);
        chk("tie_c0_hr0", {31'd0, c_hr0}, 32'd1);
        chk("tie_c0_hr1", {31'd0, c_hr1}, 32'd1);
        advance(); sample();
        chk("tie_c1_hsel", {31'd0, c_hsel}, 32'd1);
        chk("tie_c1_addr", {18'd0, c_haddr}, 32'h040);
        chk("tie_c1_hr1", {31'd0, c_hr1}, 32'd0);
        chk("tie_c1_hr0", {31'd0, c_hr0}, 32'd1);
        advance(); sample();
        chk("tie_c2_hr1", {31'd0, c_hr1}, 32'd1);
        chk("tie_c2_hsel", {31'd0, c_hsel}, 32'd0);
        drain(100);
        chk("tie_mem_020", ram[14'h020 >> 2], 32'h00000011);
        chk("tie_mem_040", ram[14'h040 >> 2], 32'h00000022);

        // Uncontended write then read of the same word.
        push(0, 1'b1, 2'b10, 1'b1, 14'h010, 32'hA5A5A5A5);
        push(0, 1'b1, 2'b10, 1'b0, 14'h010, 32'h0);
        advance(); sample();
        chk("solo_w_hsel", {31'd0, c_hsel}, 32'd1);
        chk("solo_w_addr", {18'd0, c_haddr}, 32'h010);
        chk("solo_w_write", {31'd0, c_hwrite}, 32'd1);
        chk("solo_w_hr0", {31'd0, c_hr0}, 32'd1);
        advance(); sample();
        chk("solo_r_hsel", {31'd0, c_hsel}, 32'd1);
        chk("solo_r_write", {31'd0, c_hwrite}, 32'd0);
        chk("solo_r_hr0", {31'd0, c_hr0}, 32'd1);
        chk("solo_w_hwdata", c_hwdata, 32'hA5A5A5A5);
        advance(); sample();
        chk("solo_rd_hr0", {31'd0, c_hr0}, 32'd1);
        chk("solo_rd_m0_data", c_hrdata, 32'hA5A5A5A5);
        chk("solo_rd_m1_data", m1_hrdata_o, 32'hA5A5A5A5);
        drain(100);

        // BUSY and IDLE with hsel=1 are not forwarded.
        push(0, 1'b1, 2'b01, 1'b1, 14'h080, 32'h80808080);
        push(0, 1'b1, 2'b00, 1'b1, 14'h084, 32'h84848484);
        advance(); sample();
        chk("busy_hsel", {31'd0, c_hsel}, 32'd0);
        chk("busy_hr0", {31'd0, c_hr0}, 32'd1);
        advance(); sample();
        chk("idle_hsel", {31'd0, c_hsel}, 32'd0);
        chk("idle_hr0", {31'd0, c_hr0}, 32'd1);
        drain(100);
        chk("busy_mem_080", ram[14'h080 >> 2], 32'd0);

        // Subordinate stalls two cycles in m0's data phase while m1 requests.
        push(0, 1'b1, 2'b10, 1'b1, 14'h060, 32'h60606060);
        advance(); sample();
        chk("stall_c0_hsel", {31'd0, c_hsel}, 32'd1);
        push(1, 1'b1, 2'b10, 1'b1, 14'h0A0, 32'hA0A0A0A0);
        rdy_next = 1'b0;
        advance(); sample();
        chk("stall_c1_hr0", {31'd0, c_hr0}, 32'd0);
        chk("stall_c1_hr1", {31'd0, c_hr1}, 32'd1);
        chk("stall_c1_hsel", {31'd0, c_hsel}, 32'd0);
        advance(); sample();
        chk("stall_c2_hr0", {31'd0, c_hr0}, 32'd0);
        chk("stall_c2_hr1", {31'd0, c_hr1}, 32'd0);
        chk("stall_c2_hsel", {31'd0, c_hsel}, 32'd0);
        rdy_next = 1'b1;
        advance(); sample();
        chk("stall_c3_hr0", {31'd0, c_hr0}, 32'd1);
        chk("stall_c3_hsel", {31'd0, c_hsel}, 32'd1);
        chk("stall_c3_addr", {18'd0, c_haddr}, 32'h0A0);
        chk("stall_c3_hr1", {31'd0, c_hr1}, 32'd0);
        advance(); sample();
        chk("stall_c4_hr1", {31'd0, c_hr1}, 32'd1);
        drain(100);
        chk("stall_mem_060", ram[14'h060 >> 2], 32'h60606060);
        chk("stall_mem_0A0", ram[14'h0A0 >> 2], 32'hA0A0A0A0);

        // Both managers stream four beats; m1 issued last, so m0 wins the first tie.
        ilog.delete(); wlog0.delete(); wlog1.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b1, 2'b10, 1'b1, 14'h100 + 14'(4 * i), 32'h10000000 + 32'(i));
            push(1, 1'b1, 2'b10, 1'b1, 14'h200 + 14'(4 * i), 32'h20000000 + 32'(i));
        end
        drain(100);
        chk("stream_issues", ilog.size(), 32'd8);
        for (int j = 0; j < 8; j++) begin
            a = ((j % 2) == 0 ? 14'h100 : 14'h200) + 14'(4 * (j / 2));
            chk($sformatf("stream_order%0d", j), {18'd0, (j < ilog.size()) ? ilog[j] : 14'h3FFF}, {18'd0, a});
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("stream_m0_wait%0d", j), (j < wlog0.size()) ? wlog0[j] : -1, (j == 0) ? 32'd0 : 32'd1);
            chk($sformatf("stream_m1_wait%0d", j), (j < wlog1.size()) ? wlog1[j] : -1, 32'd1);
            chk($sformatf("stream_mem_m0_%0d", j), ram[(14'h100 >> 2) + j], 32'h10000000 + 32'(j));
            chk($sformatf("stream_mem_m1_%0d", j), ram[(14'h200 >> 2) + j], 32'h20000000 + 32'(j));
        end

        // Reset while m1 is parked: nothing further reaches the RAM.
        ram[14'h300 >> 2] = 32'h33333333; ref_mem[14'h300 >> 2] = 32'h33333333;
        ram[14'h340 >> 2] = 32'h34343434; ref_mem[14'h340 >> 2] = 32'h34343434;
        push(0, 1'b1, 2'b10, 1'b1, 14'h300, 32'hDEAD0300);
        push(1, 1'b1, 2'b10, 1'b1, 14'h340, 32'hDEAD0340);
        advance(); sample();
        chk("rst_mid_c0_addr", {18'd0, c_haddr}, 32'h300);
        advance();
        arst_i = 1'b1;
        sample();
        chk("rst_mid_hr1", {31'd0, c_hr1}, 32'd1);
        chk("rst_mid_hr0", {31'd0, c_hr0}, 32'd1);
        chk("rst_mid_hsel", {31'd0, c_hsel}, 32'd0);
        chk("rst_mid_htrans", {30'd0, c_htrans}, 32'd0);
        chk("rst_mid_hwdata", c_hwdata, 32'd0);
        models_reset();
        drive();
        advance(); sample();
        arst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance(); sample();
            chk($sformatf("post_rst_hsel%0d", i), {31'd0, c_hsel}, 32'd0);
        end
        chk("rst_mem_340", ram[14'h340 >> 2], 32'h34343434);
        chk("rst_mem_300", ram[14'h300 >> 2], 32'h33333333);

        // Randomised contention with random subordinate stalls.
        rand_rdy = 1;
        for (int round = 0; round < 3; round++) begin
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < 40; n++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    a = ((k == 0) ? 14'h1000 : 14'h2000) + 14'(4 * $urandom_range(0, 15));
                    if (r == 0)      push(k, 1'b0, 2'b00, 1'b0, a, $urandom);
                    else if (r == 1) push(k, 1'b1, 2'b01, 1'b1, a, $urandom);
                    else             push(k, 1'b1, 2'b10, 1'($urandom_range(0, 1)), a, $urandom);
                end
            end
            drain(2000);
        end
        rand_rdy = 0;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("rand_mem_m0_%0d", j), ram[(14'h1000 >> 2) + j], ref_mem[(14'h1000 >> 2) + j]);
            chk($sformatf("rand_mem_m1_%0d", j), ram[(14'h2000 >> 2) + j], ref_mem[(14'h2000 >> 2) + j]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_ahb_ram_arb.md
IOB_AHB_RAM_ARB -- requirements
Module: iob_ahb_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning byte-address width forwarded to the subordinate.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data bus width; only 32 is supported.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 arst_i  input  1  asynchronous active-high reset.
REQ-006 mK_hsel_i, K=0,1  input  1  manager K subordinate select.
REQ-007 mK_haddr_i  input  ADDR_W  manager K address.
REQ-008 mK_htrans_i  input  2  manager K transfer type.
REQ-009 mK_hwrite_i  input  1  manager K write flag.
REQ-010 mK_hsize_i  input  3  manager K transfer size.
REQ-011 mK_hwdata_i  input  DATA_W  manager K write data.
REQ-012 mK_hreadyout_o  output  1  manager K ready; also that manager's HREADY.
REQ-013 mK_hrdata_o  output  DATA_W  manager K read data.
REQ-014 s_hsel_o, s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hwdata_o  output  same widths  forwarded subordinate bus.
REQ-015 s_hready_o  output  1  subordinate HREADY.
REQ-016 s_hreadyout_i  input  1  subordinate ready.
REQ-017 s_hrdata_i  input  DATA_W  subordinate read data.

Function
REQ-018 Live request K: mK_hsel_i & mK_htrans_i[1] & mK_hreadyout_o; IDLE/BUSY SHALL never be forwarded.
REQ-019 Per manager: one holding register (addr, write, size) plus pending flag; request K = live K or pending K. Pending and live for the same K SHALL never coexist.
REQ-020 Address-phase issue SHALL occur only in cycles with s_hreadyout_i=1; the granted source drives s_haddr/s_hwrite/s_hsize, s_hsel_o=1, s_htrans_o=2'b10 (NONSEQ) for every beat, since beats may interleave.
REQ-021 With no grant, s_hsel_o=0 and s_htrans_o=2'b00; address/size outputs are don't-care.
REQ-022 Arbitration: round-robin via last_grant register; single requester wins; if both request, the manager other than last_grant wins; last_grant updates only on issue.
REQ-023 A live request not issued in its cycle SHALL be captured into its holding register and set pending; pending clears in the cycle it is issued.
REQ-024 On issue, data-phase owner d_own<=K and d_vld<=1; if no issue while s_hreadyout_i=1, d_vld<=0.
REQ-025 s_hwdata_o = md_own_hwdata_i while d_vld, else 0; s_hready_o = s_hreadyout_i.
REQ-026 mK_hrdata_o = s_hrdata_i for both managers, unregistered.
REQ-027 mK_hreadyout_o = 0 if pending K; = s_hreadyout_i if d_vld & d_own=K; else 1.
REQ-028 Latency: uncontended transfer zero added wait states; losing manager gets at least one wait state per contended beat.
REQ-029 Back-to-back pipelined beats from one manager with the other idle SHALL issue every cycle.
REQ-030 Managers SHALL hold hwdata and next address stable while mK_hreadyout_o=0 (AHB-lite rule); the block relies on it.
REQ-031 No HRESP, HMASTLOCK or burst preservation; every response is OKAY by construction.

Reset
REQ-032 arst_i=1 SHALL immediately clear pending flags, d_vld, holding registers; last_grant<=1 (m0 wins first tie).
REQ-033 During reset: s_hsel_o=0, s_htrans_o=2'b00, s_hwdata_o=0, mK_hreadyout_o=1.
REQ-034 Reset mid-transfer SHALL drop held and in-flight transfers; no write reaches the subordinate after arst_i rises.

Verification
REQ-035 m0 write 0xA5A5A5A5 @0x010, m1 idle, RAM ready -> issued same cycle, m0_hreadyout_o=1 throughout, readback 0xA5A5A5A5.
REQ-036 m0 and m1 NONSEQ same cycle after reset (m0 @0x020 write 0x11, m1 @0x040 write 0x22) -> m0 issued first, m1 pending, m1_hreadyout_o=0 one cycle, m1 issued next; both words stored.
REQ-037 Both managers stream 4 beats continuously -> issues alternate m0,m1,m0,m1...; each manager sees exactly one wait state per beat after the first.
REQ-038 s_hreadyout_i held 0 two cycles during m0 data phase with m1 requesting -> m0_hreadyout_o=0 two cycles, m1 not issued until ready returns.
REQ-039 arst_i asserted while m1 pending -> m1_hreadyout_o=1 immediately, s_htrans_o=2'b00, target address unchanged in RAM.
REQ-040 m0 htrans BUSY and IDLE with hsel=1 -> never forwarded, m0_hreadyout_o=1.
